// File: rtl/parking_slot_manager.sv
// parking_slot_manager: per-slot occupancy, entry timestamps and visit counts
// for NUM_SLOTS parking slots, with a two-cycle exit billing FSM and a
// saturating revenue accumulator.
//
// Optional feature macro: PARK_OVERSTAY_EN (per-slot overstay flags and an
// overstay surcharge on exit). When undefined, overstay is tied to 0 and no
// surcharge is applied.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   car_enter, car_exit   single-cycle requests
//   car_sel               1-based slot number
//   timer_count           free-running tick counter (wraps)
//   ready                 request will be accepted this cycle
//   slot_state            per-slot occupied flags
//   enter_time_flat       per-slot entry timestamps, packed by slot
//   visit_cnt_flat        per-slot saturating entry counts, packed by slot
//   occupancy/full/empty  lot occupancy status
//   exit_valid/exit_cost/exit_slot  completed exit billing result
//   revenue               saturating sum of all fees
//   err/err_code          error pulse and held cause
//   overstay              per-slot overstay flags
module parking_slot_manager #(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned TIME_W    = 10,
  parameter int unsigned COST_W    = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RATE      = 1,
  parameter int unsigned BASE_FEE  = 0,
  parameter int unsigned MAX_STAY  = 500,
  parameter int unsigned PENALTY   = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        car_enter,
  input  logic                        car_exit,
  input  logic [SEL_W-1:0]            car_sel,
  input  logic [TIME_W-1:0]           timer_count,
  output logic                        ready,
  output logic [NUM_SLOTS-1:0]        slot_state,
  output logic [NUM_SLOTS*TIME_W-1:0] enter_time_flat,
  output logic [NUM_SLOTS*CNT_W-1:0]  visit_cnt_flat,
  output logic [SEL_W-1:0]            occupancy,
  output logic                        full,
  output logic                        empty,
  output logic                        exit_valid,
  output logic [COST_W-1:0]           exit_cost,
  output logic [SEL_W-1:0]            exit_slot,
  output logic [COST_W-1:0]           revenue,
  output logic                        err,
  output logic [2:0]                  err_code,
  output logic [NUM_SLOTS-1:0]        overstay
);

  // Wide enough for BASE_FEE + dur*RATE + PENALTY without overflow.
  localparam int unsigned CALC_W = TIME_W + COST_W + 34;
  localparam logic [CALC_W-1:0] COST_MAX = (CALC_W'(1) << COST_W) - CALC_W'(1);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, next_state;

  logic [TIME_W-1:0]    enter_time [NUM_SLOTS];
  logic [CNT_W-1:0]     visit_cnt  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] sel_hit;
  logic                 sel_valid;
  logic                 sel_occ;
  logic [TIME_W-1:0]    sel_time;
  logic [TIME_W-1:0]    dur;
  logic                 pen_now;
  logic [2:0]           req_err;
  logic                 do_enter;
  logic                 do_exit;
  logic [TIME_W-1:0]    calc_dur;
  logic                 calc_pen;
  logic [SEL_W-1:0]     calc_slot;
  logic [CALC_W-1:0]    fee_full;
  logic [COST_W-1:0]    fee;
  logic [COST_W:0]      rev_sum;

`ifdef PARK_OVERSTAY_EN
  localparam logic OVR_EN = 1'b1;
  logic [TIME_W-1:0] elapsed [NUM_SLOTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      elapsed[i] = timer_count - enter_time[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overstay <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        overstay[i] <= slot_state[i]
                       && (CALC_W'(elapsed[i]) > CALC_W'(MAX_STAY))
                       && !(do_exit && sel_hit[i]);
      end
    end
  end
`else
  localparam logic OVR_EN = 1'b0;

  always_comb begin
    overstay = '0;
  end
`endif

  // Slot decode by comparison rather than indexing so out-of-range
  // selections never address the per-slot arrays.
  always_comb begin
    sel_hit  = '0;
    sel_time = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      sel_hit[i] = (car_sel == SEL_W'(i + 1));
      if (sel_hit[i]) begin
        sel_time = enter_time[i];
      end
    end
    sel_valid = |sel_hit;
    sel_occ   = |(sel_hit & slot_state);
    dur       = timer_count - sel_time;
    pen_now   = OVR_EN && (CALC_W'(dur) > CALC_W'(MAX_STAY));
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_comb begin
    req_err = 3'd0;
    if (car_enter || car_exit) begin
      if (!ready)                      req_err = 3'd5;
      else if (car_enter && car_exit)  req_err = 3'd4;
      else if (!sel_valid)             req_err = 3'd1;
      else if (car_enter && sel_occ)   req_err = 3'd2;
      else if (car_exit && !sel_occ)   req_err = 3'd3;
    end
    do_enter = car_enter && (req_err == 3'd0);
    do_exit  = car_exit  && (req_err == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (do_exit) next_state = CALC;
      CALC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fee_full = CALC_W'(BASE_FEE) + CALC_W'(calc_dur) * CALC_W'(RATE);
    if (calc_pen) begin
      fee_full = fee_full + CALC_W'(PENALTY);
    end
    fee     = (fee_full > COST_MAX) ? '1 : fee_full[COST_W-1:0];
    rev_sum = {1'b0, revenue} + {1'b0, fee};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_state <= '0;
      occupancy  <= '0;
      err        <= 1'b0;
      err_code   <= '0;
      exit_valid <= 1'b0;
      exit_cost  <= '0;
      exit_slot  <= '0;
      revenue    <= '0;
      calc_dur   <= '0;
      calc_pen   <= 1'b0;
      calc_slot  <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        enter_time[i] <= '0;
        visit_cnt[i]  <= '0;
      end
    end else begin
      err        <= (req_err != 3'd0);
      exit_valid <= 1'b0;
      if (req_err != 3'd0) begin
        err_code <= req_err;
      end
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (sel_hit[i] && do_enter) begin
          slot_state[i] <= 1'b1;
          enter_time[i] <= timer_count;
          if (visit_cnt[i] != '1) begin
            visit_cnt[i] <= visit_cnt[i] + 1'b1;
          end
        end
        if (sel_hit[i] && do_exit) begin
          slot_state[i] <= 1'b0;
        end
      end
      if (do_enter)     occupancy <= occupancy + 1'b1;
      else if (do_exit) occupancy <= occupancy - 1'b1;
      if (do_exit) begin
        calc_dur  <= dur;
        calc_pen  <= pen_now;
        calc_slot <= car_sel;
      end
      if (state == CALC) begin
        exit_valid <= 1'b1;
        exit_cost  <= fee;
        exit_slot  <= calc_slot;
        revenue    <= rev_sum[COST_W] ? '1 : rev_sum[COST_W-1:0];
      end
    end
  end

  always_comb begin
    enter_time_flat = '0;
    visit_cnt_flat  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      enter_time_flat[i*TIME_W +: TIME_W] = enter_time[i];
      visit_cnt_flat[i*CNT_W +: CNT_W]    = visit_cnt[i];
    end
  end

  always_comb begin
    full  = (occupancy == SEL_W'(NUM_SLOTS));
    empty = (occupancy == '0);
  end

endmodule
